// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stall encoding,
// load/store type codes and the packed layouts of the three pipeline buses.
package mem_stage_pkg;

    localparam int STALL_W      = 6;
    localparam int EX_TO_MEM_WD = 146;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_ID_WD = 104;

    localparam int StallBus = STALL_W;
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int STALL_MEM_BIT = 3;
    localparam int STALL_WB_BIT  = 4;

    // The execute stage reuses ST_SB/ST_SH to build byte-lane write enables.
    localparam logic [3:0] LD_LW  = 4'b1111;
    localparam logic [3:0] LD_LB  = 4'b0001;
    localparam logic [3:0] LD_LBU = 4'b0010;
    localparam logic [3:0] LD_LH  = 4'b0011;
    localparam logic [3:0] LD_LHU = 4'b0100;
    localparam logic [3:0] ST_SB  = 4'b0101;
    localparam logic [3:0] ST_SH  = 4'b0111;

    typedef struct packed {
        logic [3:0]  ld_type;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } mem_to_id_t;

    function automatic logic is_load_code(input logic [3:0] ld_type);
        return (ld_type == LD_LW)  || (ld_type == LD_LB)  || (ld_type == LD_LBU) ||
               (ld_type == LD_LH)  || (ld_type == LD_LHU);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: picks the addressed byte/half out of the
// read word and sign- or zero-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  ld_type_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] word_i,
    output logic [31:0] result_o,
    output logic        valid_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_i)
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            2'd3:    byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        // Half-word select ignores addr_i[0]; misalignment is not trapped here.
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

        result_o = '0;
        valid_o  = 1'b1;
        case (ld_type_i)
            LD_LW:   result_o = word_i;
            LD_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result_o = {24'h0, byte_sel};
            LD_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result_o = {16'h0, half_sel};
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, aligns SRAM load
// data, holds captured load data across write-back stalls, drives WB/ID buses.
module mem_stage #(
    parameter int STALL_W      = mem_stage_pkg::STALL_W,
    parameter int EX_TO_MEM_WD = mem_stage_pkg::EX_TO_MEM_WD,
    parameter int MEM_TO_WB_WD = mem_stage_pkg::MEM_TO_WB_WD,
    parameter int MEM_TO_ID_WD = mem_stage_pkg::MEM_TO_ID_WD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    mem_is_load
);

    import mem_stage_pkg::*;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HELD  = 1'b1;

    ex_to_mem_t  bus_q, bus_d;
    logic [0:0]  hold_q, hold_d;
    logic [31:0] rdata_q, rdata_d;

    logic        mem_stop;
    logic        wb_stop;
    logic        bus_load;
    logic [31:0] rdata_eff;
    logic [31:0] ld_result;
    logic        ld_valid;
    logic [31:0] rf_wdata;
    mem_to_wb_t  wb;
    mem_to_id_t  id;

    assign mem_stop = (stall[STALL_MEM_BIT] == Stop);
    assign wb_stop  = (stall[STALL_WB_BIT] == Stop);

    // A stalled stage with a running write-back stage emits a bubble.
    always_comb begin
        bus_d    = bus_q;
        bus_load = 1'b0;
        if (!mem_stop) begin
            bus_d    = ex_to_mem_t'(ex_to_mem_bus);
            bus_load = 1'b1;
        end else if (!wb_stop) begin
            bus_d    = '0;
            bus_load = 1'b1;
        end
    end

    assign mem_is_load = bus_q.ram_en && (bus_q.ram_wen == 4'b0000);

    // The SRAM word is only valid for one cycle; capture it if write-back
    // stalls while this load sits in the stage.
    always_comb begin
        hold_d  = hold_q;
        rdata_d = rdata_q;
        if (bus_load) begin
            hold_d = EMPTY;
        end else if ((hold_q == EMPTY) && mem_is_load && wb_stop) begin
            hold_d  = HELD;
            rdata_d = data_sram_rdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q   <= '0;
            hold_q  <= EMPTY;
            rdata_q <= '0;
        end else begin
            bus_q   <= bus_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_eff = (hold_q == HELD) ? rdata_q : data_sram_rdata;

    load_align u_load_align (
        .ld_type_i (bus_q.ld_type),
        .addr_i    (bus_q.ex_result[1:0]),
        .word_i    (rdata_eff),
        .result_o  (ld_result),
        .valid_o   (ld_valid)
    );

    always_comb begin
        rf_wdata = bus_q.ex_result;
        if (bus_q.sel_rf_res) begin
            rf_wdata = ld_valid ? ld_result : rdata_eff;
        end
    end

    always_comb begin
        wb.hi_we    = bus_q.hi_we;
        wb.lo_we    = bus_q.lo_we;
        wb.hi       = bus_q.hi;
        wb.lo       = bus_q.lo;
        wb.pc       = bus_q.pc;
        wb.rf_we    = bus_q.rf_we;
        wb.rf_waddr = bus_q.rf_waddr;
        wb.rf_wdata = rf_wdata;

        id.rf_we    = bus_q.rf_we;
        id.rf_waddr = bus_q.rf_waddr;
        id.rf_wdata = rf_wdata;
        id.hi_we    = bus_q.hi_we;
        id.lo_we    = bus_q.lo_we;
        id.hi       = bus_q.hi;
        id.lo       = bus_q.lo;
    end

    assign mem_to_wb_bus = wb;
    assign mem_to_id_bus = id;

    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[STALL_W-1:STALL_WB_BIT+1], stall[STALL_MEM_BIT-1:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table-driven load/ALU vectors followed by
// hand-written stall, bubble and reset-while-held sequences.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [145:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_id_bus;
    logic         mem_is_load;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus),
        .mem_is_load     (mem_is_load)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ld;
        logic        ren;
        logic [3:0]  wen;
        logic        sel;
        logic        rwe;
        logic [31:0] res;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
        logic        exp_load;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic [3:0] ld, input logic ren, input logic [3:0] wen,
                                 input logic sel, input logic rwe, input logic [31:0] res,
                                 input logic [31:0] rdata, input logic [31:0] exp_wdata,
                                 input logic exp_load);
        vec_t v;
        v.ld = ld; v.ren = ren; v.wen = wen; v.sel = sel; v.rwe = rwe;
        v.res = res; v.rdata = rdata; v.exp_wdata = exp_wdata; v.exp_load = exp_load;
        return v;
    endfunction

    function automatic logic [145:0] mk_ex(input logic [3:0] ld, input logic hwe, input logic lwe,
                                           input logic [31:0] hi, input logic [31:0] lo,
                                           input logic [31:0] pc, input logic ren,
                                           input logic [3:0] wen, input logic sel,
                                           input logic rwe, input logic [4:0] wa,
                                           input logic [31:0] res);
        return {ld, hwe, lwe, hi, lo, pc, ren, wen, sel, rwe, wa, res};
    endfunction

    function automatic logic [135:0] mk_wb(input logic hwe, input logic lwe, input logic [31:0] hi,
                                           input logic [31:0] lo, input logic [31:0] pc,
                                           input logic rwe, input logic [4:0] wa,
                                           input logic [31:0] wd);
        return {hwe, lwe, hi, lo, pc, rwe, wa, wd};
    endfunction

    function automatic logic [103:0] mk_id(input logic rwe, input logic [4:0] wa,
                                           input logic [31:0] wd, input logic hwe,
                                           input logic lwe, input logic [31:0] hi,
                                           input logic [31:0] lo);
        return {rwe, wa, wd, hwe, lwe, hi, lo};
    endfunction

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load word at addr into the stage, deliver rdata, check rf_wdata.
    task automatic issue_lw(input string name, input logic [31:0] addr, input logic [4:0] wa,
                            input logic [31:0] rdata);
        stall = 6'b000000;
        ex_to_mem_bus = mk_ex(4'b1111, 1'b0, 1'b0, 32'h0, 32'h0, addr, 1'b1, 4'b0000,
                              1'b1, 1'b1, wa, addr);
        tick();
        data_sram_rdata = rdata;
        #1;
        check(name, 136'(mem_to_wb_bus),
              mk_wb(1'b0, 1'b0, 32'h0, 32'h0, addr, 1'b1, wa, rdata));
    endtask

    logic         hwe, lwe;
    logic [31:0]  hi, lo, pc;
    logic [4:0]   wa;
    logic [135:0] exp_lw;

    initial begin
        // LB/LBU/LH/LHU/LW extraction, fall-through codes, stores and ALU results.
        vecs.push_back(mkv(4'b0001, 1, 4'h0, 1, 1, 32'h1003, 32'h80AA_BBCC, 32'hFFFF_FF80, 1));
        vecs.push_back(mkv(4'b0010, 1, 4'h0, 1, 1, 32'h1003, 32'h80AA_BBCC, 32'h0000_0080, 1));
        vecs.push_back(mkv(4'b0011, 1, 4'h0, 1, 1, 32'h2002, 32'h8001_7FFF, 32'hFFFF_8001, 1));
        vecs.push_back(mkv(4'b0100, 1, 4'h0, 1, 1, 32'h2000, 32'h8001_7FFF, 32'h0000_7FFF, 1));
        vecs.push_back(mkv(4'b0001, 1, 4'h0, 1, 1, 32'h1000, 32'h80AA_BBCC, 32'hFFFF_FFCC, 1));
        vecs.push_back(mkv(4'b0010, 1, 4'h0, 1, 1, 32'h1001, 32'h80AA_BBCC, 32'h0000_00BB, 1));
        vecs.push_back(mkv(4'b0001, 1, 4'h0, 1, 1, 32'h1002, 32'h80AA_BBCC, 32'hFFFF_FFAA, 1));
        vecs.push_back(mkv(4'b0011, 1, 4'h0, 1, 1, 32'h2003, 32'h8001_7FFF, 32'hFFFF_8001, 1));
        vecs.push_back(mkv(4'b0011, 1, 4'h0, 1, 1, 32'h2001, 32'h8001_7FFF, 32'h0000_7FFF, 1));
        vecs.push_back(mkv(4'b0100, 1, 4'h0, 1, 1, 32'h2002, 32'h8001_7FFF, 32'h0000_8001, 1));
        vecs.push_back(mkv(4'b1111, 1, 4'h0, 1, 1, 32'h0041, 32'h1234_5678, 32'h1234_5678, 1));
        vecs.push_back(mkv(4'b0000, 1, 4'h0, 1, 1, 32'h0044, 32'hCAFE_F00D, 32'hCAFE_F00D, 1));
        vecs.push_back(mkv(4'b0101, 1, 4'h1, 0, 0, 32'h3000, 32'hFFFF_FFFF, 32'h0000_3000, 0));
        vecs.push_back(mkv(4'b0111, 1, 4'h3, 1, 0, 32'h3002, 32'h89AB_CDEF, 32'h89AB_CDEF, 0));
        vecs.push_back(mkv(4'b0000, 0, 4'h0, 0, 1, 32'h1234_ABCD, 32'h0, 32'h1234_ABCD, 0));
        vecs.push_back(mkv(4'b0001, 0, 4'h0, 0, 1, 32'h0000_5557, 32'h0, 32'h0000_5557, 0));

        // Reset dominates a busy input, then an idle input yields all-zero buses.
        rst = 1'b1;
        stall = 6'b000000;
        data_sram_rdata = 32'hFFFF_FFFF;
        ex_to_mem_bus = mk_ex(4'b1111, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 1'b1, 4'h0, 1'b1, 1'b1,
                              5'd4, 32'h5);
        tick();
        tick();
        check("reset_wb", 136'(mem_to_wb_bus), 136'h0);
        rst = 1'b0;
        ex_to_mem_bus = '0;
        data_sram_rdata = 32'h0;
        tick();
        check("idle_wb", 136'(mem_to_wb_bus), 136'h0);
        check("idle_id", 136'(mem_to_id_bus), 136'h0);
        check("idle_is_load", 136'(mem_is_load), 136'h0);

        // Table: one instruction per vector; pass-through fields vary with index.
        for (int i = 0; i < vecs.size(); i++) begin
            hwe = (i % 2) == 1;
            lwe = ((i / 2) % 2) == 1;
            hi  = 32'hA000_0000 + 32'(i);
            lo  = 32'hB000_0000 + 32'(i);
            pc  = 32'h0000_0400 + 32'(4 * i);
            wa  = 5'(i);
            stall = 6'b000000;
            ex_to_mem_bus = mk_ex(vecs[i].ld, hwe, lwe, hi, lo, pc, vecs[i].ren, vecs[i].wen,
                                  vecs[i].sel, vecs[i].rwe, wa, vecs[i].res);
            tick();
            data_sram_rdata = vecs[i].rdata;
            #1;
            check($sformatf("vec%0d_wb", i), 136'(mem_to_wb_bus),
                  mk_wb(hwe, lwe, hi, lo, pc, vecs[i].rwe, wa, vecs[i].exp_wdata));
            check($sformatf("vec%0d_id", i), 136'(mem_to_id_bus),
                  136'(mk_id(vecs[i].rwe, wa, vecs[i].exp_wdata, hwe, lwe, hi, lo)));
            check($sformatf("vec%0d_is_load", i), 136'(mem_is_load), 136'(vecs[i].exp_load));
        end

        // Downstream stall: captured word survives SRAM changes for 3 cycles.
        issue_lw("stall_lw_live", 32'h40, 5'd7, 32'h1234_5678);
        exp_lw = mk_wb(1'b0, 1'b0, 32'h0, 32'h0, 32'h40, 1'b1, 5'd7, 32'h1234_5678);
        stall = 6'b011111;
        ex_to_mem_bus = mk_ex(4'b0010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h44, 1'b1, 4'h0, 1'b1, 1'b1,
                              5'd9, 32'h44);
        for (int k = 0; k < 3; k++) begin
            tick();
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            check($sformatf("stall_hold%0d", k), 136'(mem_to_wb_bus), exp_lw);
            check($sformatf("stall_is_load%0d", k), 136'(mem_is_load), 136'h1);
        end
        stall = 6'b000000;
        ex_to_mem_bus = mk_ex(4'b1111, 1'b0, 1'b0, 32'h0, 32'h0, 32'h80, 1'b1, 4'h0, 1'b1, 1'b1,
                              5'd8, 32'h80);
        tick();
        check("stall_release_live", 136'(mem_to_wb_bus),
              mk_wb(1'b0, 1'b0, 32'h0, 32'h0, 32'h80, 1'b1, 5'd8, 32'hDEAD_BEEF));

        // Bubble clears HELD; the following load sees live data.
        issue_lw("bubble_lw_live", 32'h50, 5'd9, 32'h1111_2222);
        stall = 6'b011111;
        tick();
        data_sram_rdata = 32'h3333_4444;
        #1;
        check("bubble_pre_held", 136'(mem_to_wb_bus),
              mk_wb(1'b0, 1'b0, 32'h0, 32'h0, 32'h50, 1'b1, 5'd9, 32'h1111_2222));
        stall = 6'b001111;
        tick();
        check("bubble_wb", 136'(mem_to_wb_bus), 136'h0);
        check("bubble_id", 136'(mem_to_id_bus), 136'h0);
        check("bubble_is_load", 136'(mem_is_load), 136'h0);
        issue_lw("bubble_after_live", 32'h60, 5'd10, 32'h5555_6666);

        // ALU result with HI write passes through on both buses one cycle later.
        stall = 6'b000000;
        ex_to_mem_bus = mk_ex(4'b0000, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0, 32'h90, 1'b0, 4'h0,
                              1'b0, 1'b1, 5'd3, 32'h0000_00FF);
        tick();
        check("alu_wb", 136'(mem_to_wb_bus),
              mk_wb(1'b1, 1'b0, 32'hAAAA_0000, 32'h0, 32'h90, 1'b1, 5'd3, 32'h0000_00FF));
        check("alu_id", 136'(mem_to_id_bus),
              136'(mk_id(1'b1, 5'd3, 32'h0000_00FF, 1'b1, 1'b0, 32'hAAAA_0000, 32'h0)));

        // Reset while HELD: zero outputs, then a fresh load sees live data.
        issue_lw("rsthold_lw_live", 32'h70, 5'd11, 32'h7777_8888);
        stall = 6'b011111;
        tick();
        data_sram_rdata = 32'h9999_0000;
        #1;
        check("rsthold_held", 136'(mem_to_wb_bus),
              mk_wb(1'b0, 1'b0, 32'h0, 32'h0, 32'h70, 1'b1, 5'd11, 32'h7777_8888));
        rst = 1'b1;
        tick();
        check("rsthold_wb", 136'(mem_to_wb_bus), 136'h0);
        check("rsthold_id", 136'(mem_to_id_bus), 136'h0);
        check("rsthold_is_load", 136'(mem_is_load), 136'h0);
        rst = 1'b0;
        tick();
        check("rsthold_stalled_wb", 136'(mem_to_wb_bus), 136'h0);
        issue_lw("rsthold_after_live", 32'hA0, 5'd12, 32'hABCD_0123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
